// File: rtl/user_pixel_rom_pkg.sv
// Shared types and constants for the pixel ROM: OBI bundles,
// register offsets, CLEAR bit positions and the ROM FSM states.
package user_pixel_rom_pkg;

   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{
      AddrWidth: 32,
      DataWidth: 32,
      IdWidth:   1
   };

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } pix_obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
      logic [0:0]  rid;
   } pix_obi_rsp_t;

   localparam logic [1:0] REG_PTR    = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;

   localparam int unsigned CLR_OOB_BIT = 0;
   localparam int unsigned CLR_CNT_BIT = 1;

   // Latency counter width; ReadLatency is limited to 1..7.
   localparam int unsigned LAT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rom_state_e;

endpackage

// File: rtl/user_pixel_rom_fsm.sv
// ROM-side read FSM: accepts a byte request, holds the latched byte
// for ReadLatency cycles, then pulses rom_valid_o for one cycle.
module user_pixel_rom_fsm
   import user_pixel_rom_pkg::*;
#(
   parameter int unsigned NumPixels   = 256,
   parameter int unsigned ReadLatency = 1,
   localparam int unsigned IdxW = $clog2(NumPixels)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            rom_req_i,
   input  logic [31:0]     rom_addr_i,
   output logic [IdxW-1:0] rd_idx_o,
   input  logic [7:0]      rd_byte_i,
   output logic [7:0]      rom_data_o,
   output logic            rom_valid_o,
   output logic            busy_o,
   output logic            oob_o
);

   rom_state_e       state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             accept;
   logic             oob;

   assign rd_idx_o = rom_addr_i[IdxW-1:0];
   assign oob      = |rom_addr_i[31:IdxW];

   // Next state, latency countdown and data latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rom_req_i) begin
               accept  = 1'b1;
               data_d  = oob ? 8'h00 : rd_byte_i;
               cnt_d   = LAT_W'(ReadLatency - 1);
               state_d = (ReadLatency == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - LAT_W'(1);
            if (cnt_d == '0) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, counter and latched byte registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   assign rom_data_o  = data_q;
   assign rom_valid_o = (state_q == RESP);
   assign busy_o      = (state_q != IDLE);
   assign oob_o       = accept & oob;

endmodule

// File: rtl/user_pixel_rom.sv
// Pixel storage for the Sobel initiator, loaded over OBI.
// Optional PTR lock bit enabled by defining USER_PIXEL_ROM_LOCK_EN.
module user_pixel_rom
   import user_pixel_rom_pkg::*;
#(
   parameter obi_cfg_t    ObiCfg      = ObiDefaultConfig,
   parameter type         obi_req_t   = pix_obi_req_t,
   parameter type         obi_rsp_t   = pix_obi_rsp_t,
   parameter int unsigned NumPixels   = 256,
   parameter int unsigned ReadLatency = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  obi_req_t    obi_req_i,
   output obi_rsp_t    obi_rsp_o,
   input  logic        rom_req_i,
   input  logic [31:0] rom_addr_i,
   output logic [7:0]  rom_data_o,
   output logic        rom_valid_o,
   output logic        busy_o
);

   localparam int unsigned IdxW = $clog2(NumPixels);

   logic [7:0]      mem_q [NumPixels];
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            oob_q, oob_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            rvalid_q;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [ObiCfg.IdWidth-1:0] rid_q;

   logic [IdxW-1:0] byte_idx [4];
   logic [IdxW-1:0] rd_idx;
   logic            oob_set;
   logic            mem_we;
   logic            clr_oob, clr_cnt;
   logic [1:0]      reg_sel;
   logic            unused_addr;

   assign reg_sel     = obi_req_i.addr[3:2];
   assign unused_addr = ^{obi_req_i.addr[31:4], obi_req_i.addr[1:0]};

`ifdef USER_PIXEL_ROM_LOCK_EN
   logic lock_q, lock_d;

   // Lock bit shares the PTR register with the pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) lock_q <= 1'b0;
      else       lock_q <= lock_d;
   end
`else
   logic lock_q;
   assign lock_q = 1'b0;
`endif

   user_pixel_rom_fsm #(
      .NumPixels   (NumPixels),
      .ReadLatency (ReadLatency)
   ) u_fsm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rom_req_i   (rom_req_i),
      .rom_addr_i  (rom_addr_i),
      .rd_idx_o    (rd_idx),
      .rd_byte_i   (mem_q[rd_idx]),
      .rom_data_o  (rom_data_o),
      .rom_valid_o (rom_valid_o),
      .busy_o      (busy_o),
      .oob_o       (oob_set)
   );

   // Byte lanes of a DATA access, wrapping inside the storage.
   always_comb begin
      for (int k = 0; k < 4; k++) byte_idx[k] = ptr_q + IdxW'(k);
   end

   // OBI register decode.
   always_comb begin
      ptr_d   = ptr_q;
`ifdef USER_PIXEL_ROM_LOCK_EN
      lock_d  = lock_q;
`endif
      rdata_d = '0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      clr_oob = 1'b0;
      clr_cnt = 1'b0;
      if (obi_req_i.req) begin
         unique case (reg_sel)
            REG_PTR: begin
               if (obi_req_i.we) begin
                  ptr_d  = obi_req_i.wdata[IdxW-1:0];
`ifdef USER_PIXEL_ROM_LOCK_EN
                  lock_d = obi_req_i.wdata[31];
`endif
               end else begin
                  rdata_d = {lock_q, {(31-IdxW){1'b0}}, ptr_q};
               end
            end
            REG_DATA: begin
               if (obi_req_i.we) begin
                  if (lock_q) begin
                     err_d = 1'b1;
                  end else begin
                     mem_we = 1'b1;
                     ptr_d  = ptr_q + IdxW'(4);
                  end
               end else begin
                  rdata_d = {mem_q[byte_idx[3]], mem_q[byte_idx[2]],
                             mem_q[byte_idx[1]], mem_q[byte_idx[0]]};
               end
            end
            REG_STATUS: begin
               if (obi_req_i.we) err_d = 1'b1;
               else rdata_d = {15'b0, oob_q, cnt_q};
            end
            REG_CLEAR: begin
               if (obi_req_i.we) begin
                  clr_oob = obi_req_i.wdata[CLR_OOB_BIT];
                  clr_cnt = obi_req_i.wdata[CLR_CNT_BIT];
               end else begin
                  err_d = 1'b1;
               end
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   // Software clears take priority over same-cycle ROM events.
   always_comb begin
      oob_d = clr_oob ? 1'b0 : (oob_q | oob_set);
      cnt_d = clr_cnt ? 16'd0 : cnt_q + 16'(rom_valid_o);
   end

   // Pointer, status and OBI response registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q    <= '0;
         oob_q    <= 1'b0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rid_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         oob_q    <= oob_d;
         cnt_q    <= cnt_d;
         rvalid_q <= obi_req_i.req;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rid_q    <= obi_req_i.aid;
      end
   end

   // Pixel storage; byte-enabled writes from the DATA register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumPixels; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (obi_req_i.be[k]) begin
               mem_q[byte_idx[k]] <= obi_req_i.wdata[8*k +: 8];
            end
         end
      end
   end

   // Response bundle.
   always_comb begin
      obi_rsp_o        = '0;
      obi_rsp_o.gnt    = obi_req_i.req;
      obi_rsp_o.rvalid = rvalid_q;
      obi_rsp_o.rdata  = rdata_q;
      obi_rsp_o.err    = err_q;
      obi_rsp_o.rid    = rid_q;
   end

endmodule
